// File: rtl/i2c_codec_target.sv
// Write-only I2C target emulating the WM8731 control port: captures 3-byte frames
// (address+W, two register bytes) and presents a 7-bit register address and 9-bit data.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       reg_wr,
  output logic       busy,
  output logic       nack_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_IGNORE
  } state_t;

  logic       scl_meta_q, scl_sync_q, scl_prev_q;
  logic       sda_meta_q, sda_sync_q, sda_prev_q;
  logic [2:0] drv_hist_q;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte1_q, byte1_d;
  logic       sda_oe_q, sda_oe_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [8:0] reg_data_q, reg_data_d;
  logic       reg_wr_q, reg_wr_d;
  logic       nack_err_q, nack_err_d;

  logic       scl_rise, scl_fall, start_ev, stop_ev, own_mask;
  logic [7:0] byte_full;

  assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;

  // Events are masked while our own drive (and its synchronizer echo) is in flight
  assign own_mask  = sda_oe_q | (|drv_hist_q);
  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_ev  = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q & ~own_mask;
  assign stop_ev   = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q & ~own_mask;
  assign byte_full = {shift_q[6:0], sda_sync_q};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte1_d    = byte1_q;
    sda_oe_d   = sda_oe_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    reg_wr_d   = 1'b0;
    nack_err_d = nack_err_q;

    if (start_ev) begin
      state_d    = S_ADDR;
      bit_cnt_d  = 3'd0;
      nack_err_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else if (stop_ev) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (scl_rise) begin
            shift_d   = byte_full;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                S_ADDR: begin
                  if (byte_full[7:1] == DEV_ADDR && !byte_full[0]) begin
                    state_d = S_ACK_A;
                  end else begin
                    if (byte_full[7:1] == DEV_ADDR) nack_err_d = 1'b1;
                    state_d = S_IGNORE;
                  end
                end
                S_BYTE1: begin
                  byte1_d = byte_full;
                  state_d = S_ACK_1;
                end
                default: state_d = S_ACK_2;
              endcase
            end
          end
        end
        S_ACK_A, S_ACK_1, S_ACK_2: begin
          // First fall starts the ACK drive, second fall ends it
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              case (state_q)
                S_ACK_A: state_d = S_BYTE1;
                S_ACK_1: state_d = S_BYTE2;
                default: begin
                  state_d    = S_IGNORE;
                  reg_addr_d = byte1_q[7:1];
                  reg_data_d = {byte1_q[0], shift_q};
                  reg_wr_d   = 1'b1;
                end
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      drv_hist_q <= 3'd0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      sda_oe_q   <= 1'b0;
      reg_addr_q <= 7'd0;
      reg_data_q <= 9'd0;
      reg_wr_q   <= 1'b0;
      nack_err_q <= 1'b0;
    end else begin
      scl_meta_q <= i2c_sclk;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= i2c_sdat;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
      drv_hist_q <= {drv_hist_q[1:0], sda_oe_q};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sda_oe_q   <= sda_oe_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      reg_wr_q   <= reg_wr_d;
      nack_err_q <= nack_err_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    byte1_q <= byte1_d;
  end

  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;
  assign reg_wr   = reg_wr_q;
  assign busy     = (state_q != S_IDLE);
  assign nack_err = nack_err_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: bit-banged I2C master plus a frame-level model of
// which bytes get ACKed, which writes result, and when nack_err/busy must be set.
module tb_i2c_codec_target;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_oe = 1'b0;
  wire        sda_bus;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       reg_wr;
  logic       busy;
  logic       nack_err;

  assign sda_bus = m_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_codec_target #(.DEV_ADDR(7'h1A)) dut (
    .clk(clk), .reset(reset), .i2c_sclk(m_scl), .i2c_sdat(sda_bus),
    .reg_addr(reg_addr), .reg_data(reg_data), .reg_wr(reg_wr),
    .busy(busy), .nack_err(nack_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] exp_wr[$];
  logic [15:0] wr_e;
  logic [6:0]  m_last_addr = 7'd0;
  logic [8:0]  m_last_data = 9'd0;
  bit          allow_drive = 1'b0;
  bit          exp_nack = 1'b0;
  bit          addr_ok = 1'b0;
  int          idx = 0;
  logic [7:0]  m_b1 = 8'd0;
  int          wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of register outputs, write strobes and SDA ownership
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_wr) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_reg_wr", 32'd1, 32'd0);
        end else begin
          wr_e = exp_wr.pop_front();
          chk("wr_addr", 32'(reg_addr), 32'(wr_e[15:9]));
          chk("wr_data", 32'(reg_data), 32'(wr_e[8:0]));
          m_last_addr = wr_e[15:9];
          m_last_data = wr_e[8:0];
          wr_seen++;
        end
      end else begin
        chk("hold_addr", 32'(reg_addr), 32'(m_last_addr));
        chk("hold_data", 32'(reg_data), 32'(m_last_data));
      end
      if (!m_oe && !allow_drive) chk("sda_stray_drive", 32'(sda_bus), 32'd1);
    end
  end

  task automatic m_start();
    if (!m_scl) begin
      tick(4); m_oe = 1'b0;
      tick(4); m_scl = 1'b1;
    end
    tick(4); m_oe = 1'b1;
    idx = 0; addr_ok = 1'b0; exp_nack = 1'b0;
    tick(4); m_scl = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("nack_clr_on_start", 32'(nack_err), 32'd0);
  endtask

  task automatic m_stop();
    tick(4); m_oe = 1'b1;
    tick(4); m_scl = 1'b1;
    tick(4); m_oe = 1'b0;
    tick(8);
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("nack_at_stop", 32'(nack_err), 32'(exp_nack));
    chk("pending_writes", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rst_in_ack);
    bit exp_ack;
    exp_ack = 1'b0;
    if (idx == 0) begin
      addr_ok = (b[7:1] == 7'h1A) && !b[0];
      if (b[7:1] == 7'h1A && b[0]) exp_nack = 1'b1;
      exp_ack = addr_ok;
    end else if (idx == 1) begin
      exp_ack = addr_ok;
      m_b1 = b;
    end else if (idx == 2) begin
      exp_ack = addr_ok;
      if (addr_ok) exp_wr.push_back({m_b1[7:1], m_b1[0], b});
    end
    for (int i = 7; i >= 0; i--) begin
      tick(4); m_oe = ~b[i];
      tick(4); m_scl = 1'b1;
      tick(8);
      if (i == 0) allow_drive = exp_ack;
      m_scl = 1'b0;
    end
    tick(4); m_oe = 1'b0;
    tick(4); m_scl = 1'b1;
    tick(4);
    if (rst_in_ack) begin
      chk("ack_before_reset", 32'(sda_bus), 32'd0);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      m_last_addr = 7'd0; m_last_data = 9'd0;
      exp_nack = 1'b0; allow_drive = 1'b0; addr_ok = 1'b0;
      chk("sda_released_after_reset", 32'(sda_bus), 32'd1);
      chk("busy_after_reset", 32'(busy), 32'd0);
      chk("reg_wr_after_reset", 32'(reg_wr), 32'd0);
      chk("addr_after_reset", 32'(reg_addr), 32'd0);
      tick(3); m_scl = 1'b0;
      tick(6);
    end else begin
      chk($sformatf("ack_byte%0d", idx), 32'(sda_bus), exp_ack ? 32'd0 : 32'd1);
      tick(4); m_scl = 1'b0;
      tick(6); allow_drive = 1'b0;
    end
    idx++;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit open;
    int nb;
    logic [7:0] b;

    tick(5);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_data", 32'(reg_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_nack", 32'(nack_err), 32'd0);
    chk("rst_wr", 32'(reg_wr), 32'd0);
    chk("rst_sda", 32'(sda_bus), 32'd1);
    reset = 1'b0;
    tick(5);
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic frame
    m_start(); send_byte(8'h34, 0); send_byte(8'h1E, 0); send_byte(8'h00, 0); m_stop();
    chk("t1_addr", 32'(reg_addr), 32'h0F);
    chk("t1_data", 32'(reg_data), 32'h000);
    chk("t1_wr_count", 32'(wr_seen), 32'd1);

    // Back-to-back frames with repeated START
    m_start(); send_byte(8'h34, 0); send_byte(8'h0D, 0); send_byte(8'hFF, 0);
    m_start(); send_byte(8'h34, 0); send_byte(8'h08, 0); send_byte(8'h12, 0); m_stop();
    chk("t2_addr", 32'(reg_addr), 32'h04);
    chk("t2_data", 32'(reg_data), 32'h012);
    chk("t2_wr_count", 32'(wr_seen), 32'd3);

    // Foreign device address
    m_start(); send_byte(8'h36, 0); send_byte(8'hAA, 0); send_byte(8'h55, 0); m_stop();
    chk("t3_nack", 32'(nack_err), 32'd0);
    chk("t3_wr_count", 32'(wr_seen), 32'd3);

    // Read request gets NACKed, then a valid frame clears nack_err
    m_start(); send_byte(8'h35, 0); send_byte(8'h11, 0);
    chk("t4_nack_set", 32'(nack_err), 32'd1);
    m_start(); send_byte(8'h34, 0); send_byte(8'h0A, 0); send_byte(8'h5C, 0); m_stop();
    chk("t4_nack_clr", 32'(nack_err), 32'd0);
    chk("t4_addr", 32'(reg_addr), 32'h05);
    chk("t4_data", 32'(reg_data), 32'h05C);

    // Truncated frame keeps previous register values
    m_start(); send_byte(8'h34, 0); send_byte(8'h1E, 0); m_stop();
    chk("t5_addr", 32'(reg_addr), 32'h05);
    chk("t5_data", 32'(reg_data), 32'h05C);
    chk("t5_wr_count", 32'(wr_seen), 32'd4);

    // Fourth byte is NACKed
    m_start(); send_byte(8'h34, 0); send_byte(8'h02, 0); send_byte(8'h55, 0); send_byte(8'hAA, 0); m_stop();
    chk("t6_wr_count", 32'(wr_seen), 32'd5);
    chk("t6_data", 32'(reg_data), 32'h055);

    // Reset while driving ACK after byte 1, then a full frame
    m_start(); send_byte(8'h34, 0); send_byte(8'h1E, 1); m_stop();
    m_start(); send_byte(8'h34, 0); send_byte(8'h1F, 0); send_byte(8'h80, 0); m_stop();
    chk("t7_addr", 32'(reg_addr), 32'h0F);
    chk("t7_data", 32'(reg_data), 32'h180);
    chk("t7_wr_count", 32'(wr_seen), 32'd6);

    // Random frames
    open = 1'b0;
    for (int f = 0; f < 30; f++) begin
      m_start();
      nb = $urandom_range(0, 4);
      for (int k = 0; k < nb; k++) begin
        if (k == 0) begin
          case ($urandom_range(0, 3))
            0: b = 8'h34;
            1: b = 8'h35;
            2: b = 8'h36;
            default: b = 8'($urandom);
          endcase
        end else begin
          b = 8'($urandom);
        end
        send_byte(b, 0);
      end
      open = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        m_stop();
        open = 1'b0;
      end
    end
    if (open) m_stop();
    chk("final_pending", 32'(exp_wr.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
